uart_transmit: RTL and testbench
================================

# uart_transmit

UART transmitter, the sending counterpart of the team's UART receiver. It accepts bytes over a valid/ready handshake into a small FIFO and serialises them onto `tx_wire_out` as 8N1 frames, LSB first, at a fixed baud rate. It sits between on-chip byte producers and the FPGA TX pin.

## Interface
- `INPUT_CLOCK_FREQ`, default 100_000_000: clock frequency in Hz.
- `BAUD_RATE`, default 9600: line rate in bit/s.
- `FIFO_DEPTH`, default 4: byte FIFO entries; must be a power of two and at least 2.
- `clk_in`  input  1  system clock; all logic on its rising edge.
- `rst_n_in`  input  1  reset; asynchronous and active-low.
- `data_byte_in`  input  8  byte to send.
- `valid_in`  input  1  `data_byte_in` is valid.
- `ready_out`  output  1  the FIFO can accept a byte.
- `tx_wire_out`  output  1  serial line; idles high.
- `busy_out`  output  1  a frame is in progress or the FIFO is not empty.

## Operation
- `BAUD_BIT_PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE` uses integer division. Every line bit lasts exactly `BAUD_BIT_PERIOD` cycles.
- Push: a byte is accepted on a rising edge where `valid_in && ready_out`.
  - `ready_out = !fifo_full`.
  - `valid_in` while `ready_out` is low is ignored; no data is lost or corrupted.
- States: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- IDLE
  - `tx_wire_out = 1`.
  - If the FIFO was non-empty before the edge: pop, load the shift register, enter START, and drive `tx_wire_out` low on that edge.
- START: line low for one period, then enter DATA with `bit_index = 0`.
- DATA
  - Drive `shift[bit_index]`, LSB first, for one period each.
  - After bit 7, go to PARITY if it is compiled in, otherwise to STOP.
- STOP: line high for one period. On its final cycle:
  - FIFO non-empty: pop and enter START directly, so frames go back to back with no idle gap.
  - FIFO empty: go to IDLE.
- Counter widths
  - `period_count` is `$clog2(BAUD_BIT_PERIOD)` bits and counts 0..BAUD_BIT_PERIOD-1, then wraps to 0 on each bit boundary.
  - `bit_index` is 3 bits.
- There is no bypass path: a byte pushed into an empty FIFO is popped no earlier than the following edge.
- A push and a pop on the same edge are both honoured, and the FIFO count is unchanged.
- `busy_out = (state != IDLE) || !fifo_empty`.

## Timing
- Reset values: `tx_wire_out = 1`, `ready_out = 1`, `busy_out = 0`, FIFO empty, state IDLE.
- Reset asserted mid-frame:
  - Outputs take their reset values immediately, without waiting for a clock.
  - The partial frame and the FIFO contents are discarded.
- Latency: a byte accepted at edge k into an empty FIFO while idle makes `tx_wire_out` fall at edge k+1.
- Frame length: 10·BAUD_BIT_PERIOD cycles without parity, 11·BAUD_BIT_PERIOD cycles with parity.
- `tx_wire_out` is driven from a flop and is glitch-free.
- After the last stop bit with an empty FIFO, `busy_out` falls on the same edge that enters IDLE.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined:
  - The PARITY state is present.
  - It transmits one even-parity bit, `^byte`, for one period between D7 and the stop bit.
- Undefined: the PARITY state and its logic are absent, and the format is 8N1.

## Structure
- Package `uart_pkg` holds:
  - `uart_tx_state_t`, the state enum.
  - Constants `UART_DATA_BITS = 8`, `UART_START_LEVEL = 1'b0`, `UART_STOP_LEVEL = 1'b1`.
  - The helper function that computes the baud period.
- Sub-module `uart_tx_fifo`:
  - Synchronous FIFO, parameterised by `FIFO_DEPTH`, async active-low reset.
  - Ports: push, pop, din, dout, full, empty.
  - Pointers are one bit wider than the address to distinguish full from empty.

## Test plan
All scenarios use `INPUT_CLOCK_FREQ = 1000` and `BAUD_RATE = 100`, so the bit period is 10 cycles.
- Reset: after release, `tx_wire_out = 1`, `ready_out = 1`, `busy_out = 0`, and the line stays high for 50 idle cycles.
- Single byte 0xA5:
  - The line falls 1 cycle after accept, with the start bit low for 10 cycles.
  - Data then reads 1,0,1,0,0,1,0,1 at 10 cycles each, followed by 10 cycles high.
  - `busy_out` falls exactly 100 cycles after the line fell.
- Burst:
  - Hold `valid_in` high with 0x00..0x05, `FIFO_DEPTH = 4`.
  - `ready_out` drops after the 5th accept; the 6th byte is accepted only after a pop.
  - All 6 frames are contiguous, 600 cycles in total, in order, with no idle gap.
- Backpressure: pulse `valid_in` with 0xFF while `ready_out = 0`. The byte is never transmitted, and the FIFO count is unchanged.
- Parity (macro defined): 0x07 sends parity bit 1 and 0x03 sends parity bit 0; each frame is 110 cycles.
- Reset during D3 of 0x5A with 2 bytes queued:
  - `tx_wire_out` goes to 1 with no clock edge.
  - After release, only a newly pushed 0x3C appears, framed correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types, constants and helpers for the UART transmitter.
//   uart_tx_state_t  transmitter FSM state encoding
//   UART_DATA_BITS   data bits per frame
//   UART_START_LEVEL line level of the start bit
//   UART_STOP_LEVEL  line level of the stop bit and of the idle line
//   baud_period()    clock cycles per line bit (integer division)
// Optional feature macro: UART_TX_PARITY_EN adds the PARITY state.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS   = 8;
    localparam logic        UART_START_LEVEL = 1'b0;
    localparam logic        UART_STOP_LEVEL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } uart_tx_state_t;

    function automatic int unsigned baud_period(input int unsigned clk_hz,
                                                input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO feeding the UART transmitter.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset, empties the FIFO
//   push   write din (ignored while full)
//   pop    advance the read pointer (ignored while empty)
//   din    write data
//   dout   head-of-queue data, valid while !empty
//   full   no free entry
//   empty  no stored entry
// FIFO_DEPTH must be a power of two and at least 2.
module uart_tx_fifo #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WIDTH      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_transmit.sv
// uart_transmit: byte-stream to serial UART transmitter (8N1, LSB first).
//   clk_in        system clock, rising edge
//   rst_n_in      asynchronous active-low reset
//   data_byte_in  byte to send
//   valid_in      data_byte_in valid; accepted when ready_out is high
//   ready_out     FIFO can accept a byte
//   tx_wire_out   registered serial line, idles high
//   busy_out      frame in progress or bytes still queued
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit
// between D7 and the stop bit (8E1).
module uart_transmit
    import uart_pkg::*;
#(
    parameter int unsigned INPUT_CLOCK_FREQ = 100_000_000,
    parameter int unsigned BAUD_RATE        = 9600,
    parameter int unsigned FIFO_DEPTH       = 4
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic [7:0] data_byte_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       tx_wire_out,
    output logic       busy_out
);

    localparam int unsigned BAUD_BIT_PERIOD = baud_period(INPUT_CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned CNT_W = (BAUD_BIT_PERIOD > 1) ? $clog2(BAUD_BIT_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_BIT_PERIOD - 1);
    localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t   state;
    logic [CNT_W-1:0] period_count;
    logic [2:0]       bit_index;
    logic [7:0]       shift;
    logic             tx_reg;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_dout;
    logic             bit_done;

    assign bit_done  = (period_count == CNT_LAST);
    assign fifo_push = valid_in && !fifo_full;

    // Pops happen only where the FSM loads the shift register: from IDLE,
    // or on the last stop-bit cycle to chain frames without a gap.
    always_comb begin
        fifo_pop = 1'b0;
        case (state)
            IDLE:    fifo_pop = !fifo_empty;
            STOP:    fifo_pop = bit_done && !fifo_empty;
            default: fifo_pop = 1'b0;
        endcase
    end

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (UART_DATA_BITS)
    ) u_fifo (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (data_byte_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Line level is registered one state ahead: each transition writes the
    // level of the bit that the new state transmits.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state        <= IDLE;
            period_count <= '0;
            bit_index    <= '0;
            shift        <= '0;
            tx_reg       <= UART_STOP_LEVEL;
        end else begin
            case (state)
                IDLE: begin
                    period_count <= '0;
                    tx_reg       <= UART_STOP_LEVEL;
                    if (fifo_pop) begin
                        shift  <= fifo_dout;
                        tx_reg <= UART_START_LEVEL;
                        state  <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        period_count <= '0;
                        bit_index    <= '0;
                        tx_reg       <= shift[0];
                        state        <= DATA;
                    end else begin
                        period_count <= period_count + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        period_count <= '0;
                        if (bit_index == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            tx_reg <= ^shift;
                            state  <= PARITY;
`else
                            tx_reg <= UART_STOP_LEVEL;
                            state  <= STOP;
`endif
                        end else begin
                            bit_index <= bit_index + 3'd1;
                            tx_reg    <= shift[bit_index + 3'd1];
                        end
                    end else begin
                        period_count <= period_count + CNT_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        period_count <= '0;
                        tx_reg       <= UART_STOP_LEVEL;
                        state        <= STOP;
                    end else begin
                        period_count <= period_count + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (bit_done) begin
                        period_count <= '0;
                        if (fifo_pop) begin
                            shift  <= fifo_dout;
                            tx_reg <= UART_START_LEVEL;
                            state  <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        period_count <= period_count + CNT_W'(1);
                    end
                end
                default: begin
                    period_count <= '0;
                    tx_reg       <= UART_STOP_LEVEL;
                    state        <= IDLE;
                end
            endcase
        end
    end

    assign ready_out   = !fifo_full;
    assign tx_wire_out = tx_reg;
    assign busy_out    = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_transmit.sv
// tb_uart_transmit: directed self-checking bench for uart_transmit with a
// 10-cycle bit period (1000 Hz clock, 100 baud). Build with
// UART_TX_PARITY_EN defined to exercise the parity frame format.
module tb_uart_transmit;

    localparam int unsigned FREQ   = 1000;
    localparam int unsigned BAUD   = 100;
    localparam int          PERIOD = 10;
`ifdef UART_TX_PARITY_EN
    localparam int          FRAME_BITS = 11;
`else
    localparam int          FRAME_BITS = 10;
`endif

    typedef logic [7:0] byte_q_t [$];

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] data  = '0;
    logic       ready;
    logic       tx;
    logic       busy;

    int unsigned cyc    = 0;
    int          checks = 0;
    int          errors = 0;

    int unsigned acc_edge[$];
    logic        acc_ready[$];

    uart_transmit #(
        .INPUT_CLOCK_FREQ (FREQ),
        .BAUD_RATE        (BAUD),
        .FIFO_DEPTH       (4)
    ) dut (
        .clk_in       (clk),
        .rst_n_in     (rst_n),
        .data_byte_in (data),
        .valid_in     (valid),
        .ready_out    (ready),
        .tx_wire_out  (tx),
        .busy_out     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected line level for frame bit idx of byte b.
    function automatic logic exp_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic push_byte(input logic [7:0] b, input string tag);
        bit done = 1'b0;
        @(negedge clk);
        data  = b;
        valid = 1'b1;
        for (int t = 0; t < 3000 && !done; t++) begin
            if (ready) begin
                @(posedge clk);
                #1;
                acc_edge.push_back(cyc);
                acc_ready.push_back(ready);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_accept: byte %h got no accept, expected accept", tag, b);
        end
    endtask

    task automatic push_seq(input byte_q_t q, input string tag);
        for (int i = 0; i < q.size(); i++) push_byte(q[i], tag);
    endtask

    // Waits for the start bit, checks every cycle of the frames in q, then
    // checks busy drops and the line idles right after the last stop cycle.
    task automatic expect_frames(input byte_q_t q, input string tag,
                                 output int unsigned fall_edge);
        bit   seen = 1'b0;
        logic e;
        fall_edge = 0;
        for (int t = 0; t < 3000 && !seen; t++) begin
            step();
            if (tx === 1'b0) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_start: line never fell, expected start bit", tag);
            return;
        end
        fall_edge = cyc;
        for (int f = 0; f < q.size(); f++) begin
            for (int b = 0; b < FRAME_BITS; b++) begin
                for (int c = 0; c < PERIOD; c++) begin
                    if (!(f == 0 && b == 0 && c == 0)) step();
                    e = exp_bit(q[f], b);
                    checks++;
                    if (tx !== e) begin
                        errors++;
                        $display("FAIL %s_line frame %0d bit %0d cycle %0d: got %b expected %b",
                                 tag, f, b, c, tx, e);
                    end
                end
            end
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy_last_stop: got %b expected 1", tag, busy);
        end
        step();
        checks++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            errors++;
            $display("FAIL %s_idle_after: got busy=%b tx=%b expected busy=0 tx=1", tag, busy, tx);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: got tx=%b ready=%b busy=%b expected 1 1 0", tx, ready, busy);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got tx=%b ready=%b busy=%b expected 1 1 0", tx, ready, busy);
        end
        for (int i = 0; i < 50; i++) begin
            step();
            checks++;
            if (tx !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: got tx=%b busy=%b expected 1 0", i, tx, busy);
            end
        end
    endtask

    task automatic test_single();
        byte_q_t     q;
        int unsigned fall;
        q = {8'hA5};
        acc_edge.delete();
        acc_ready.delete();
        push_byte(8'hA5, "single");
        checks++;
        if (tx !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_after_accept: got tx=%b busy=%b expected 1 1", tx, busy);
        end
        expect_frames(q, "single", fall);
        checks++;
        if (acc_edge.size() != 1 || fall != acc_edge[0] + 1) begin
            errors++;
            $display("FAIL single_latency: got fall edge %0d expected accept edge + 1", fall);
        end
    endtask

    task automatic test_burst();
        byte_q_t     q;
        int unsigned fall;
        q = {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        acc_edge.delete();
        acc_ready.delete();
        fork
            push_seq(q, "burst");
            expect_frames(q, "burst", fall);
        join
        checks++;
        if (acc_edge.size() != 6) begin
            errors++;
            $display("FAIL burst_accepts: got %0d accepts expected 6", acc_edge.size());
        end else begin
            for (int i = 1; i < 5; i++) begin
                checks++;
                if (acc_edge[i] != acc_edge[0] + i) begin
                    errors++;
                    $display("FAIL burst_contig_accept %0d: got edge %0d expected %0d",
                             i, acc_edge[i], acc_edge[0] + i);
                end
            end
            checks++;
            if (acc_ready[3] !== 1'b1 || acc_ready[4] !== 1'b0) begin
                errors++;
                $display("FAIL burst_ready_drop: got %b/%b after accepts 4/5 expected 1/0",
                         acc_ready[3], acc_ready[4]);
            end
            checks++;
            if (acc_edge[5] != fall + FRAME_BITS * PERIOD + 1) begin
                errors++;
                $display("FAIL burst_sixth_accept: got edge %0d expected %0d",
                         acc_edge[5], fall + FRAME_BITS * PERIOD + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        byte_q_t     q;
        int unsigned fall;
        q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        acc_edge.delete();
        acc_ready.delete();
        fork
            begin
                push_seq(q, "bp");
                @(negedge clk);
                checks++;
                if (ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_full: got ready=%b expected 0", ready);
                end
                data  = 8'hFF;
                valid = 1'b1;
                @(posedge clk);
                #1;
                valid = 1'b0;
                checks++;
                if (ready !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_after_pulse: got ready=%b busy=%b expected 0 1", ready, busy);
                end
            end
            expect_frames(q, "bp", fall);
        join
    endtask

    task automatic test_reset_mid_frame();
        byte_q_t     q;
        byte_q_t     q2;
        int unsigned fall;
        int unsigned target;
        q  = {8'h5A, 8'h11, 8'h22};
        q2 = {8'h3C};
        acc_edge.delete();
        acc_ready.delete();
        push_seq(q, "rstmid");
        target = (acc_edge.size() > 0) ? acc_edge[0] + 1 + 44 : cyc;
        for (int t = 0; t < 200 && cyc < target; t++) step();
        checks++;
        if (tx !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_in_d3: got tx=%b busy=%b expected 1 1", tx, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: got tx=%b ready=%b busy=%b expected 1 1 0", tx, ready, busy);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (tx !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_discard cycle %0d: got tx=%b busy=%b expected 1 0", i, tx, busy);
            end
        end
        acc_edge.delete();
        acc_ready.delete();
        push_byte(8'h3C, "rstmid_new");
        expect_frames(q2, "rstmid_new", fall);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        byte_q_t     q;
        int unsigned fall;
        q = {8'h07, 8'h03};
        acc_edge.delete();
        acc_ready.delete();
        fork
            push_seq(q, "parity");
            expect_frames(q, "parity", fall);
        join
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
